// File: rtl/z80fi_insn_capture.sv
// Builds one retirement packet per instruction from the core's trace strobes and
// emits it with a one-cycle z80fi_valid. Optional sticky error flag: Z80FI_CAPTURE_ERR_EN.
module z80fi_insn_capture #(
    parameter int MAX_INSN_LEN = 4,
    parameter int REGS_W       = 160
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_insn_start,
    input  logic                      cpu_insn_done,
    input  logic [REGS_W-1:0]         cpu_regs,
    input  logic                      cpu_fetch_valid,
    input  logic [7:0]                cpu_fetch_data,
    input  logic                      cpu_rd_valid,
    input  logic [15:0]               cpu_rd_addr,
    input  logic [7:0]                cpu_rd_data,
    input  logic                      cpu_wr_valid,
    input  logic [15:0]               cpu_wr_addr,
    input  logic [7:0]                cpu_wr_data,
    output logic                      z80fi_valid,
    output logic [8*MAX_INSN_LEN-1:0] z80fi_insn,
    output logic [2:0]                z80fi_insn_len,
    output logic [15:0]               z80fi_mem_raddr,
    output logic [15:0]               z80fi_mem_raddr2,
    output logic [7:0]                z80fi_mem_rdata,
    output logic [7:0]                z80fi_mem_rdata2,
    output logic [15:0]               z80fi_mem_waddr,
    output logic [15:0]               z80fi_mem_waddr2,
    output logic [7:0]                z80fi_mem_wdata,
    output logic [7:0]                z80fi_mem_wdata2,
    output logic [REGS_W-1:0]         z80fi_regs_in,
    output logic [REGS_W-1:0]         z80fi_regs_out,
    output logic                      capture_err
);

    localparam int         INSN_W  = 8 * MAX_INSN_LEN;
    localparam logic [2:0] MAX_LEN = 3'(MAX_INSN_LEN);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Working packet
    logic [INSN_W-1:0] work_insn_q, work_insn_d;
    logic [2:0]        work_len_q, work_len_d;
    logic [1:0]        work_rcnt_q, work_rcnt_d;
    logic [1:0]        work_wcnt_q, work_wcnt_d;
    logic [15:0]       work_raddr_q, work_raddr_d, work_raddr2_q, work_raddr2_d;
    logic [7:0]        work_rdata_q, work_rdata_d, work_rdata2_q, work_rdata2_d;
    logic [15:0]       work_waddr_q, work_waddr_d, work_waddr2_q, work_waddr2_d;
    logic [7:0]        work_wdata_q, work_wdata_d, work_wdata2_q, work_wdata2_d;
    logic [REGS_W-1:0] work_regs_in_q, work_regs_in_d;

    // Output register
    logic              out_valid_q, out_valid_d;
    logic [INSN_W-1:0] out_insn_q, out_insn_d;
    logic [2:0]        out_len_q, out_len_d;
    logic [15:0]       out_raddr_q, out_raddr_d, out_raddr2_q, out_raddr2_d;
    logic [7:0]        out_rdata_q, out_rdata_d, out_rdata2_q, out_rdata2_d;
    logic [15:0]       out_waddr_q, out_waddr_d, out_waddr2_q, out_waddr2_d;
    logic [7:0]        out_wdata_q, out_wdata_d, out_wdata2_q, out_wdata2_d;
    logic [REGS_W-1:0] out_regs_in_q, out_regs_in_d;
    logic [REGS_W-1:0] out_regs_out_q, out_regs_out_d;

    logic active, retire, fetch_en, rd_en, wr_en;

    assign active   = cpu_insn_start || (state_q == S_COLLECT);
    assign retire   = (state_q == S_COLLECT) && cpu_insn_done;
    assign fetch_en = active && cpu_fetch_valid;
    assign rd_en    = active && cpu_rd_valid;
    assign wr_en    = active && cpu_wr_valid;

    // A start wipes the packet before this cycle's strobes are applied
    logic [INSN_W-1:0] base_insn, upd_insn;
    logic [2:0]        base_len, upd_len;
    logic [1:0]        base_rcnt, upd_rcnt, base_wcnt, upd_wcnt;
    logic [15:0]       base_raddr, base_raddr2, base_waddr, base_waddr2;
    logic [7:0]        base_rdata, base_rdata2, base_wdata, base_wdata2;
    logic [15:0]       upd_raddr, upd_raddr2, upd_waddr, upd_waddr2;
    logic [7:0]        upd_rdata, upd_rdata2, upd_wdata, upd_wdata2;

    assign base_insn   = cpu_insn_start ? '0 : work_insn_q;
    assign base_len    = cpu_insn_start ? '0 : work_len_q;
    assign base_rcnt   = cpu_insn_start ? '0 : work_rcnt_q;
    assign base_wcnt   = cpu_insn_start ? '0 : work_wcnt_q;
    assign base_raddr  = cpu_insn_start ? '0 : work_raddr_q;
    assign base_raddr2 = cpu_insn_start ? '0 : work_raddr2_q;
    assign base_rdata  = cpu_insn_start ? '0 : work_rdata_q;
    assign base_rdata2 = cpu_insn_start ? '0 : work_rdata2_q;
    assign base_waddr  = cpu_insn_start ? '0 : work_waddr_q;
    assign base_waddr2 = cpu_insn_start ? '0 : work_waddr2_q;
    assign base_wdata  = cpu_insn_start ? '0 : work_wdata_q;
    assign base_wdata2 = cpu_insn_start ? '0 : work_wdata2_q;

    generate
        for (genvar gi = 0; gi < MAX_INSN_LEN; gi++) begin : g_insn_byte
            assign upd_insn[8*gi +: 8] = (fetch_en && (base_len == 3'(gi)))
                                         ? cpu_fetch_data : base_insn[8*gi +: 8];
        end
    endgenerate

    assign upd_len = (fetch_en && (base_len != MAX_LEN)) ? base_len + 3'd1 : base_len;

    always_comb begin
        upd_raddr  = base_raddr;
        upd_rdata  = base_rdata;
        upd_raddr2 = base_raddr2;
        upd_rdata2 = base_rdata2;
        upd_rcnt   = base_rcnt;
        if (rd_en) begin
            case (base_rcnt)
                2'd0: begin
                    upd_raddr = cpu_rd_addr;
                    upd_rdata = cpu_rd_data;
                    upd_rcnt  = 2'd1;
                end
                2'd1: begin
                    upd_raddr2 = cpu_rd_addr;
                    upd_rdata2 = cpu_rd_data;
                    upd_rcnt   = 2'd2;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        upd_waddr  = base_waddr;
        upd_wdata  = base_wdata;
        upd_waddr2 = base_waddr2;
        upd_wdata2 = base_wdata2;
        upd_wcnt   = base_wcnt;
        if (wr_en) begin
            case (base_wcnt)
                2'd0: begin
                    upd_waddr = cpu_wr_addr;
                    upd_wdata = cpu_wr_data;
                    upd_wcnt  = 2'd1;
                end
                2'd1: begin
                    upd_waddr2 = cpu_wr_addr;
                    upd_wdata2 = cpu_wr_data;
                    upd_wcnt   = 2'd2;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        work_insn_d    = work_insn_q;
        work_len_d     = work_len_q;
        work_rcnt_d    = work_rcnt_q;
        work_wcnt_d    = work_wcnt_q;
        work_raddr_d   = work_raddr_q;
        work_rdata_d   = work_rdata_q;
        work_raddr2_d  = work_raddr2_q;
        work_rdata2_d  = work_rdata2_q;
        work_waddr_d   = work_waddr_q;
        work_wdata_d   = work_wdata_q;
        work_waddr2_d  = work_waddr2_q;
        work_wdata2_d  = work_wdata2_q;
        work_regs_in_d = work_regs_in_q;
        out_valid_d    = 1'b0;
        out_insn_d     = out_insn_q;
        out_len_d      = out_len_q;
        out_raddr_d    = out_raddr_q;
        out_rdata_d    = out_rdata_q;
        out_raddr2_d   = out_raddr2_q;
        out_rdata2_d   = out_rdata2_q;
        out_waddr_d    = out_waddr_q;
        out_wdata_d    = out_wdata_q;
        out_waddr2_d   = out_waddr2_q;
        out_wdata2_d   = out_wdata2_q;
        out_regs_in_d  = out_regs_in_q;
        out_regs_out_d = out_regs_out_q;

        // With a same-cycle start, this cycle's strobes belong to the new packet,
        // so the retiring packet is the working packet as it stood.
        if (retire) begin
            out_valid_d    = 1'b1;
            out_insn_d     = cpu_insn_start ? work_insn_q   : upd_insn;
            out_len_d      = cpu_insn_start ? work_len_q    : upd_len;
            out_raddr_d    = cpu_insn_start ? work_raddr_q  : upd_raddr;
            out_rdata_d    = cpu_insn_start ? work_rdata_q  : upd_rdata;
            out_raddr2_d   = cpu_insn_start ? work_raddr2_q : upd_raddr2;
            out_rdata2_d   = cpu_insn_start ? work_rdata2_q : upd_rdata2;
            out_waddr_d    = cpu_insn_start ? work_waddr_q  : upd_waddr;
            out_wdata_d    = cpu_insn_start ? work_wdata_q  : upd_wdata;
            out_waddr2_d   = cpu_insn_start ? work_waddr2_q : upd_waddr2;
            out_wdata2_d   = cpu_insn_start ? work_wdata2_q : upd_wdata2;
            out_regs_in_d  = work_regs_in_q;
            out_regs_out_d = cpu_regs;
        end

        if (active) begin
            work_insn_d   = upd_insn;
            work_len_d    = upd_len;
            work_rcnt_d   = upd_rcnt;
            work_wcnt_d   = upd_wcnt;
            work_raddr_d  = upd_raddr;
            work_rdata_d  = upd_rdata;
            work_raddr2_d = upd_raddr2;
            work_rdata2_d = upd_rdata2;
            work_waddr_d  = upd_waddr;
            work_wdata_d  = upd_wdata;
            work_waddr2_d = upd_waddr2;
            work_wdata2_d = upd_wdata2;
        end

        if (cpu_insn_start) begin
            work_regs_in_d = cpu_regs;
            state_d        = S_COLLECT;
        end else if (retire) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            work_insn_q    <= '0;
            work_len_q     <= '0;
            work_rcnt_q    <= '0;
            work_wcnt_q    <= '0;
            work_raddr_q   <= '0;
            work_rdata_q   <= '0;
            work_raddr2_q  <= '0;
            work_rdata2_q  <= '0;
            work_waddr_q   <= '0;
            work_wdata_q   <= '0;
            work_waddr2_q  <= '0;
            work_wdata2_q  <= '0;
            work_regs_in_q <= '0;
            out_valid_q    <= 1'b0;
            out_insn_q     <= '0;
            out_len_q      <= '0;
            out_raddr_q    <= '0;
            out_rdata_q    <= '0;
            out_raddr2_q   <= '0;
            out_rdata2_q   <= '0;
            out_waddr_q    <= '0;
            out_wdata_q    <= '0;
            out_waddr2_q   <= '0;
            out_wdata2_q   <= '0;
            out_regs_in_q  <= '0;
            out_regs_out_q <= '0;
        end else begin
            state_q        <= state_d;
            work_insn_q    <= work_insn_d;
            work_len_q     <= work_len_d;
            work_rcnt_q    <= work_rcnt_d;
            work_wcnt_q    <= work_wcnt_d;
            work_raddr_q   <= work_raddr_d;
            work_rdata_q   <= work_rdata_d;
            work_raddr2_q  <= work_raddr2_d;
            work_rdata2_q  <= work_rdata2_d;
            work_waddr_q   <= work_waddr_d;
            work_wdata_q   <= work_wdata_d;
            work_waddr2_q  <= work_waddr2_d;
            work_wdata2_q  <= work_wdata2_d;
            work_regs_in_q <= work_regs_in_d;
            out_valid_q    <= out_valid_d;
            out_insn_q     <= out_insn_d;
            out_len_q      <= out_len_d;
            out_raddr_q    <= out_raddr_d;
            out_rdata_q    <= out_rdata_d;
            out_raddr2_q   <= out_raddr2_d;
            out_rdata2_q   <= out_rdata2_d;
            out_waddr_q    <= out_waddr_d;
            out_wdata_q    <= out_wdata_d;
            out_waddr2_q   <= out_waddr2_d;
            out_wdata2_q   <= out_wdata2_d;
            out_regs_in_q  <= out_regs_in_d;
            out_regs_out_q <= out_regs_out_d;
        end
    end

`ifdef Z80FI_CAPTURE_ERR_EN
    logic err_q, err_d;
    logic ovf_err, idle_err, restart_err;

    assign ovf_err     = (fetch_en && (base_len == MAX_LEN)) ||
                         (rd_en && (base_rcnt == 2'd2)) ||
                         (wr_en && (base_wcnt == 2'd2));
    // Done is never meaningful in IDLE, even alongside a start
    assign idle_err    = (state_q == S_IDLE) &&
                         (cpu_insn_done ||
                          (!cpu_insn_start && (cpu_fetch_valid || cpu_rd_valid || cpu_wr_valid)));
    assign restart_err = (state_q == S_COLLECT) && cpu_insn_start && !cpu_insn_done;

    always_comb begin
        err_d = err_q | ovf_err | idle_err | restart_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign capture_err = err_q;
`else
    assign capture_err = 1'b0;
`endif

    assign z80fi_valid      = out_valid_q;
    assign z80fi_insn       = out_insn_q;
    assign z80fi_insn_len   = out_len_q;
    assign z80fi_mem_raddr  = out_raddr_q;
    assign z80fi_mem_rdata  = out_rdata_q;
    assign z80fi_mem_raddr2 = out_raddr2_q;
    assign z80fi_mem_rdata2 = out_rdata2_q;
    assign z80fi_mem_waddr  = out_waddr_q;
    assign z80fi_mem_wdata  = out_wdata_q;
    assign z80fi_mem_waddr2 = out_waddr2_q;
    assign z80fi_mem_wdata2 = out_wdata2_q;
    assign z80fi_regs_in    = out_regs_in_q;
    assign z80fi_regs_out   = out_regs_out_q;

endmodule
